// File: rtl/rv_tb_pkg.sv
// Shared types for the rv_run_ctrl run controller and writeback checker.
// Holds the FSM state enum, the expected-writeback entry and the error cap.
package rv_tb_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [7:0] ERR_SAT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } run_state_e;

    typedef struct packed {
        logic [4:0]          a;
        logic [PKG_XLEN-1:0] d;
    } exp_entry_t;

endpackage

// File: rtl/rv_run_ctrl_if.sv
// Bundle between a host/bench (master) and rv_run_ctrl (slave).
// Ports: start/stop_pc/exp_cnt run control, pc_in + wb_* core side,
// exp_* table write port, and the status returned by the controller.
interface rv_run_ctrl_if #(
    parameter int XLEN = 32,
    parameter int IW   = 2
);

    logic            start;
    logic [XLEN-1:0] stop_pc;
    logic [XLEN-1:0] pc_in;
    logic            wb_e;
    logic [4:0]      wb_a;
    logic [XLEN-1:0] wb_d;
    logic            exp_we;
    logic [IW-1:0]   exp_idx;
    logic [4:0]      exp_a;
    logic [XLEN-1:0] exp_d;
    logic [IW:0]     exp_cnt;
    logic            core_reset;
    logic            dump;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timed_out;
    logic [7:0]      err_cnt;
    logic [IW:0]     chk_ptr;

    modport master (
        output start, stop_pc, pc_in, wb_e, wb_a, wb_d,
        output exp_we, exp_idx, exp_a, exp_d, exp_cnt,
        input  core_reset, dump, busy, done, pass,
        input  timed_out, err_cnt, chk_ptr
    );

    modport slave (
        input  start, stop_pc, pc_in, wb_e, wb_a, wb_d,
        input  exp_we, exp_idx, exp_a, exp_d, exp_cnt,
        output core_reset, dump, busy, done, pass,
        output timed_out, err_cnt, chk_ptr
    );

endinterface

// File: rtl/rv_wb_checker.sv
// In-order writeback checker: expected table, consume pointer, error count.
// Ports: en/clr from the FSM, tbl_* write port, wb_* stream, counts out.
module rv_wb_checker
    import rv_tb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NCHK = 4,
    parameter int IW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    input  logic            tbl_we,
    input  logic [IW-1:0]   tbl_idx,
    input  logic [4:0]      tbl_a,
    input  logic [XLEN-1:0] tbl_d,
    input  logic [IW:0]     exp_cnt,
    input  logic            wb_e,
    input  logic [4:0]      wb_a,
    input  logic [XLEN-1:0] wb_d,
    output logic [IW:0]     chk_ptr,
    output logic [7:0]      err_cnt,
    output logic [IW:0]     chk_ptr_nxt,
    output logic [7:0]      err_cnt_nxt
);

    exp_entry_t  tbl_q [NCHK];
    exp_entry_t  cur;
    logic [IW:0] ptr_q, ptr_d;
    logic [7:0]  err_q, err_d;
    logic        bad;
    logic        in_range;

    assign in_range = {1'b0, tbl_idx} < (IW+1)'(NCHK);

    always_comb begin
        cur   = tbl_q[ptr_q[IW-1:0]];
        ptr_d = ptr_q;
        err_d = err_q;
        bad   = 1'b0;
        if (clr) begin
            ptr_d = '0;
            err_d = '0;
        end else if (en && wb_e && (wb_a != 5'd0)) begin
            if (ptr_q < exp_cnt) begin
                ptr_d = ptr_q + (IW+1)'(1);
                bad   = (wb_a != cur.a) || (wb_d != cur.d);
            end else begin
                // surplus writeback beyond the table
                bad = 1'b1;
            end
        end
        if (bad && (err_q != ERR_SAT)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
            err_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    // table contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (tbl_we && in_range) begin
            tbl_q[tbl_idx] <= '{a: tbl_a, d: tbl_d};
        end
    end

    assign chk_ptr     = ptr_q;
    assign err_cnt     = err_q;
    assign chk_ptr_nxt = ptr_d;
    assign err_cnt_nxt = err_d;

endmodule

// File: rtl/rv_run_ctrl.sv
// Run controller: hold core in reset, run to stop_pc or timeout, drain, dump.
// Ports: clk, reset (sync, active-low), bus (rv_run_ctrl_if.slave).
module rv_run_ctrl
    import rv_tb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RST_HOLD = 20,
    parameter int DRAIN    = 4,
    parameter int TIMEOUT  = 2000,
    parameter int NCHK     = 4
) (
    input logic        clk,
    input logic        reset,
    rv_run_ctrl_if.slave bus
);

    localparam int IW     = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam int MAXC_A = (RST_HOLD > DRAIN) ? RST_HOLD : DRAIN;
    localparam int MAXC   = (MAXC_A > TIMEOUT) ? MAXC_A : TIMEOUT;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

    // with no drain the stop goes straight to the dump cycle
    localparam run_state_e AFTER_RUN = (DRAIN == 0) ? S_DUMP : S_DRAIN;

    run_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] stop_pc_q, stop_pc_d;
    logic [IW:0]     exp_cnt_q, exp_cnt_d;
    logic            core_reset_q, core_reset_d;
    logic            dump_q, dump_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            timed_out_q, timed_out_d;

    logic        ctl_idle;
    logic        go;
    logic        chk_en;
    logic [IW:0] ptr_nxt;
    logic [7:0]  err_nxt;

    assign ctl_idle = (state_q == S_IDLE) || (state_q == S_DONE);
    assign go       = ctl_idle && bus.start;
    assign chk_en   = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                      (state_q == S_DUMP);

    rv_wb_checker #(
        .XLEN (XLEN),
        .NCHK (NCHK),
        .IW   (IW)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .en          (chk_en),
        .clr         (go),
        .tbl_we      (bus.exp_we && ctl_idle),
        .tbl_idx     (bus.exp_idx),
        .tbl_a       (bus.exp_a),
        .tbl_d       (bus.exp_d),
        .exp_cnt     (exp_cnt_q),
        .wb_e        (bus.wb_e),
        .wb_a        (bus.wb_a),
        .wb_d        (bus.wb_d),
        .chk_ptr     (bus.chk_ptr),
        .err_cnt     (bus.err_cnt),
        .chk_ptr_nxt (ptr_nxt),
        .err_cnt_nxt (err_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stop_pc_d   = stop_pc_q;
        exp_cnt_d   = exp_cnt_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    stop_pc_d   = bus.stop_pc;
                    exp_cnt_d   = bus.exp_cnt;
                    pass_d      = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                // stop has priority over a coincident timeout
                if (bus.pc_in >= stop_pc_q) begin
                    state_d = AFTER_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = AFTER_RUN;
                    cnt_d       = '0;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DUMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DUMP: begin
                // next-state counts so a DUMP-cycle writeback is included
                state_d = S_DONE;
                pass_d  = !timed_out_q && (err_nxt == 8'd0) &&
                          (ptr_nxt == exp_cnt_q);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        core_reset_d = (state_d == S_IDLE) || (state_d == S_HOLD) ||
                       (state_d == S_DONE);
        dump_d       = (state_d == S_DUMP);
        busy_d       = (state_d == S_HOLD) || (state_d == S_RUN) ||
                       (state_d == S_DRAIN) || (state_d == S_DUMP);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stop_pc_q    <= '0;
            exp_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            dump_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stop_pc_q    <= stop_pc_d;
            exp_cnt_q    <= exp_cnt_d;
            core_reset_q <= core_reset_d;
            dump_q       <= dump_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.dump       = dump_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.timed_out  = timed_out_q;

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Scoreboard bench for rv_run_ctrl: directed runs on two parameter sets.
// Stimulus pushes expected dump results; negedge monitors pop and compare.
module tb_rv_run_ctrl;

    typedef struct {
        string      nm;
        int         dcyc;
        logic       pass;
        logic [7:0] err;
        logic [2:0] ptr;
        logic       to;
    } exp_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur[2];
    bit   pend[2];
    wb_t  wbq[$];

    rv_run_ctrl_if #(.XLEN(32), .IW(2)) ifa ();
    rv_run_ctrl_if #(.XLEN(32), .IW(2)) ifb ();

    virtual rv_run_ctrl_if #(.XLEN(32), .IW(2)) va;
    virtual rv_run_ctrl_if #(.XLEN(32), .IW(2)) vb;

    rv_run_ctrl #(
        .XLEN(32), .RST_HOLD(20), .DRAIN(4), .TIMEOUT(50), .NCHK(4)
    ) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    rv_run_ctrl #(
        .XLEN(32), .RST_HOLD(3), .DRAIN(0), .TIMEOUT(50), .NCHK(4)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic dmp, input logic dn,
                       input logic ps, input logic to,
                       input logic [7:0] ec, input logic [2:0] cp);
        exp_t e;
        if (dmp === 1'b1) begin
            if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL dut%0d unexpected_dump: got dump at cyc %0d want none",
                         k, cyc);
            end else begin
                if (k == 0) e = qa.pop_front();
                else e = qb.pop_front();
                cur[k]  = e;
                pend[k] = 1'b1;
                chk($sformatf("%s/dump_cyc", e.nm), cyc, e.dcyc);
            end
        end else if (pend[k]) begin
            pend[k] = 1'b0;
            e = cur[k];
            chk($sformatf("%s/done", e.nm), dn, 1);
            chk($sformatf("%s/pass", e.nm), ps, e.pass);
            chk($sformatf("%s/timed_out", e.nm), to, e.to);
            chk($sformatf("%s/err_cnt", e.nm), ec, e.err);
            chk($sformatf("%s/chk_ptr", e.nm), cp, e.ptr);
        end
    endtask

    always @(negedge clk)
        mon(0, ifa.dump, ifa.done, ifa.pass, ifa.timed_out,
            ifa.err_cnt, ifa.chk_ptr);

    always @(negedge clk)
        mon(1, ifb.dump, ifb.done, ifb.pass, ifb.timed_out,
            ifb.err_cnt, ifb.chk_ptr);

    task automatic init_if(input int k);
        virtual rv_run_ctrl_if #(.XLEN(32), .IW(2)) v;
        if (k == 0) v = va;
        else v = vb;
        v.start   = 1'b0;
        v.stop_pc = '0;
        v.pc_in   = '0;
        v.wb_e    = 1'b0;
        v.wb_a    = '0;
        v.wb_d    = '0;
        v.exp_we  = 1'b0;
        v.exp_idx = '0;
        v.exp_a   = '0;
        v.exp_d   = '0;
        v.exp_cnt = '0;
    endtask

    task automatic tbl_wr(input int k, input logic [1:0] idx,
                          input logic [4:0] a, input logic [31:0] d);
        virtual rv_run_ctrl_if #(.XLEN(32), .IW(2)) v;
        if (k == 0) v = va;
        else v = vb;
        @(posedge clk); #1;
        v.exp_we  = 1'b1;
        v.exp_idx = idx;
        v.exp_a   = a;
        v.exp_d   = d;
        @(posedge clk); #1;
        v.exp_we  = 1'b0;
    endtask

    function automatic void set_wbs(input int kind);
        wbq.delete();
        if (kind == 1 || kind == 2 || kind == 3 || kind == 4) begin
            wbq.push_back('{a: 5'd1, d: 32'hDEADBEEF});
            if (kind == 3) wbq.push_back('{a: 5'd0, d: 32'h5});
            if (kind == 2) wbq.push_back('{a: 5'd2, d: 32'h12345679});
            else wbq.push_back('{a: 5'd2, d: 32'h12345678});
            if (kind == 3) wbq.push_back('{a: 5'd0, d: 32'h77});
            wbq.push_back('{a: 5'd7, d: 32'h4});
            if (kind == 4) wbq.push_back('{a: 5'd5, d: 32'h99});
        end
    endfunction

    task automatic run_case(input int k, input string nm, input logic [2:0] ecnt,
                            input int stop_c, input bit poke, input bit ws,
                            input logic ep, input logic [7:0] ee,
                            input logic [2:0] eptr, input logic eto);
        virtual rv_run_ctrl_if #(.XLEN(32), .IW(2)) v;
        exp_t e;
        int   n, r, lim, hold, drn;
        if (k == 0) v = va;
        else v = vb;
        hold = (k == 0) ? 20 : 3;
        drn  = (k == 0) ? 4 : 0;
        @(posedge clk); #1;
        v.start   = 1'b1;
        v.stop_pc = 32'd52;
        v.exp_cnt = ecnt;
        v.pc_in   = '0;
        if (ws) begin
            v.exp_we  = 1'b1;
            v.exp_idx = 2'd2;
            v.exp_a   = 5'd7;
            v.exp_d   = 32'h4;
        end
        @(posedge clk); #1;
        n = cyc;
        v.start   = 1'b0;
        v.exp_we  = 1'b0;
        v.stop_pc = '0;
        v.exp_cnt = '0;
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            v.start = 1'b1;
            @(posedge clk); #1;
            v.start = 1'b0;
        end
        lim = 0;
        while (v.core_reset !== 1'b0 && lim < 100) begin
            @(posedge clk); #1;
            lim++;
        end
        r = cyc;
        chk($sformatf("%s/hold_len", nm), r - n, hold);
        v.pc_in = 32'd12;
        for (int i = 0; i < wbq.size(); i++) begin
            v.wb_e = 1'b1;
            v.wb_a = wbq[i].a;
            v.wb_d = wbq[i].d;
            if (poke && i == 0) begin
                v.start   = 1'b1;
                v.exp_we  = 1'b1;
                v.exp_idx = 2'd1;
                v.exp_a   = 5'd2;
                v.exp_d   = 32'hAAAA;
            end
            @(posedge clk); #1;
            v.start  = 1'b0;
            v.exp_we = 1'b0;
        end
        v.wb_e = 1'b0;
        e.nm   = nm;
        e.pass = ep;
        e.err  = ee;
        e.ptr  = eptr;
        e.to   = eto;
        if (stop_c >= 0) begin
            while (cyc < r + stop_c) begin
                @(posedge clk); #1;
            end
            v.pc_in = 32'd52;
            e.dcyc  = cyc + 1 + drn;
        end else begin
            e.dcyc = r + 50 + drn;
        end
        if (k == 0) qa.push_back(e);
        else qb.push_back(e);
        lim = 0;
        while (v.done !== 1'b1 && lim < 300) begin
            @(posedge clk); #1;
            lim++;
        end
        if (lim >= 300) chk($sformatf("%s/done_wait", nm), v.done, 1);
        v.pc_in = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        int lim;
        @(posedge clk); #1;
        ifa.start   = 1'b1;
        ifa.stop_pc = 32'd52;
        ifa.exp_cnt = 3'd3;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        lim = 0;
        while (ifa.core_reset !== 1'b0 && lim < 100) begin
            @(posedge clk); #1;
            lim++;
        end
        ifa.pc_in = 32'd12;
        ifa.wb_e  = 1'b1;
        ifa.wb_a  = 5'd1;
        ifa.wb_d  = 32'hDEADBEEF;
        @(posedge clk); #1;
        ifa.wb_e = 1'b0;
        chk("mid/ptr_before", ifa.chk_ptr, 1);
        chk("mid/busy_before", ifa.busy, 1);
        rst_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk);
        chk("mid/core_reset", ifa.core_reset, 1);
        chk("mid/busy", ifa.busy, 0);
        chk("mid/dump", ifa.dump, 0);
        chk("mid/done", ifa.done, 0);
        chk("mid/pass", ifa.pass, 0);
        chk("mid/timed_out", ifa.timed_out, 0);
        chk("mid/err_cnt", ifa.err_cnt, 0);
        chk("mid/chk_ptr", ifa.chk_ptr, 0);
        @(negedge clk);
        chk("mid/stays_idle", ifa.busy, 0);
        ifa.pc_in = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        va = ifa;
        vb = ifb;
        init_if(0);
        init_if(1);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst/core_reset", ifa.core_reset, 1);
        chk("rst/dump", ifa.dump, 0);
        chk("rst/busy", ifa.busy, 0);
        chk("rst/done", ifa.done, 0);
        chk("rst/pass", ifa.pass, 0);
        chk("rst/timed_out", ifa.timed_out, 0);
        chk("rst/err_cnt", ifa.err_cnt, 0);
        chk("rst/chk_ptr", ifa.chk_ptr, 0);
        chk("rst/b_core_reset", ifb.core_reset, 1);

        tbl_wr(0, 2'd0, 5'd1, 32'hDEADBEEF);
        tbl_wr(0, 2'd1, 5'd2, 32'h12345678);
        tbl_wr(1, 2'd0, 5'd1, 32'hDEADBEEF);
        tbl_wr(1, 2'd1, 5'd2, 32'h12345678);

        set_wbs(1);
        run_case(0, "basic", 3'd3, 3, 1'b0, 1'b1, 1'b1, 8'd0, 3'd3, 1'b0);
        set_wbs(2);
        run_case(0, "mismatch", 3'd3, 3, 1'b0, 1'b0, 1'b0, 8'd1, 3'd3, 1'b0);
        set_wbs(3);
        run_case(0, "x0_ignored", 3'd3, 5, 1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 1'b0);
        set_wbs(4);
        run_case(0, "surplus", 3'd3, 4, 1'b0, 1'b0, 1'b0, 8'd1, 3'd3, 1'b0);
        set_wbs(0);
        run_case(0, "timeout", 3'd3, -1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        run_case(0, "stop_and_to", 3'd0, 49, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 1'b0);
        set_wbs(1);
        run_case(0, "start_poke", 3'd3, 3, 1'b1, 1'b0, 1'b1, 8'd0, 3'd3, 1'b0);
        reset_mid();
        run_case(0, "replay", 3'd3, 3, 1'b0, 1'b0, 1'b1, 8'd0, 3'd3, 1'b0);
        run_case(1, "drain0", 3'd3, 3, 1'b0, 1'b1, 1'b1, 8'd0, 3'd3, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_left_a", qa.size(), 0);
        chk("sb_left_b", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_run_ctrl.md
# rv_run_ctrl

Synthesizable run controller and writeback checker for `riscv_pipeline`, replacing hand-written timed bench sequences. It holds the core in reset, runs the core until the PC reaches a programmable stop address or a cycle budget expires, and drains the pipeline. It then pulses `dump` and reports pass/fail. While the core runs, it compares the in-order writeback stream (`wb_e`/`wb_a`/`wb_d`) against a loadable table of expected register writes.

## Interface
- `XLEN`, 32: data and PC width.
- `RST_HOLD`, 20: cycles `core_reset` is held high after start, ≥1.
- `DRAIN`, 4: cycles waited after the stop condition before `dump`, ≥0.
- `TIMEOUT`, 2000: maximum RUN cycles before forced stop, ≥1.
- `NCHK`, 4: expected-writeback table depth, ≥1; `IW = max(1,$clog2(NCHK))`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: starts a run. Sampled only in IDLE or DONE.
- `stop_pc` in XLEN: stop when `pc_in >= stop_pc` (unsigned), sampled at `start`.
- `pc_in` in XLEN: core `pc_out`.
- `wb_e` in 1, `wb_a` in 5, `wb_d` in XLEN: core writeback port.
- `exp_we` in 1, `exp_idx` in IW, `exp_a` in 5, `exp_d` in XLEN: expected-table write port. Ignored outside IDLE/DONE.
- `exp_cnt` in IW+1: number of valid table entries (0..NCHK), sampled at `start`.
- `core_reset` out 1: active-high reset to core.
- `dump` out 1: one-cycle register-dump strobe to core.
- `busy`, `done`, `pass`, `timed_out` out 1: status.
- `err_cnt` out 8: mismatch count, saturating at 255.
- `chk_ptr` out IW+1: entries consumed.

## Operation
- FSM states: IDLE, HOLD, RUN, DRAIN, DUMP, DONE.
- IDLE/DONE: on `start`, clear `err_cnt`, `chk_ptr`, `timed_out`, `pass`, and latch `stop_pc` and `exp_cnt`. Go to HOLD.
- HOLD: `core_reset`=1 for exactly RST_HOLD cycles, then RUN.
- RUN: a cycle counter starts at 0 and increments each cycle.
  - `pc_in >= stop_pc` → DRAIN.
  - Otherwise, counter reaching TIMEOUT−1 → set `timed_out`, go to DRAIN.
  - If both are true in the same cycle, the stop wins and `timed_out` stays 0.
- DRAIN: exactly DRAIN cycles, then DUMP. With DRAIN=0, go directly RUN→DUMP.
- DUMP: `dump`=1 for one cycle, then DONE.
- DONE: `done`=1 and hold all status until `start` or reset.
- `pass` is registered on DUMP→DONE. It is 1 iff `!timed_out && err_cnt==0 && chk_ptr==exp_cnt_latched`.
- Checker is active in RUN, DRAIN and DUMP only:
  - Writebacks with `wb_a==0` are ignored.
  - On a `wb_e` with `chk_ptr < exp_cnt_latched`: compare `{wb_a,wb_d}` against entry `chk_ptr`; increment `chk_ptr`; on mismatch, increment `err_cnt`.
  - On a `wb_e` with `chk_ptr == exp_cnt_latched` (surplus writeback): increment `err_cnt`; `chk_ptr` unchanged.
- Table writes during a run are dropped. A write and `start` in the same cycle: the write lands and `start` is honored.
- `start` in HOLD/RUN/DRAIN/DUMP is ignored. No restart mid-run.

## Timing
- Reset (`reset`=0 at edge) → IDLE from any state.
  - Outputs after reset: `core_reset`=1, `dump`=0, `busy`=0, `done`=0, `pass`=0, `timed_out`=0, `err_cnt`=0, `chk_ptr`=0.
  - Table contents are not reset.
- `core_reset` is 1 in IDLE, HOLD and DONE, and 0 in RUN, DRAIN and DUMP.
- `busy`=1 in HOLD, RUN, DRAIN and DUMP.
- Cycle accounting:
  - `start` at edge N: the FSM enters HOLD at edge N.
  - RUN is entered at N+RST_HOLD.
  - Stop detected in RUN at edge M: `dump` is high during cycle M+DRAIN+1, and `done` is high from M+DRAIN+2.
- All outputs are registered. Checker compare latency is 1 cycle, so `err_cnt` updates the edge after `wb_e`.
- A writeback in the DUMP cycle is still checked and is reflected in `pass`.

## Structure
- Package `rv_tb_pkg`: `run_state_e` enum; `exp_entry_t` struct {`logic [4:0] a; logic [XLEN-1:0] d`}; `ERR_SAT` constant.
- Sub-module `rv_wb_checker` holds the expected table, `chk_ptr`, the compare logic and `err_cnt`. It has an enable input driven by the FSM.
- The top holds the FSM and the HOLD/RUN/DRAIN counters, sized with `$clog2` of the largest of RST_HOLD, DRAIN and TIMEOUT.

## Test plan
- **Basic run:** RST_HOLD=20, DRAIN=4, stop_pc=52, table = {x1=DEADBEEF, x2=12345678, x7=4}, `exp_cnt`=3. Model core emits those three writebacks, then PC reaches 52 → `dump` one cycle exactly 5 cycles after the stop edge; `pass`=1, `err_cnt`=0, `chk_ptr`=3.
- **Data mismatch:** same as basic, but x2 written as 12345679 → `err_cnt`=1, `chk_ptr`=3, `pass`=0.
- **Timeout:** TIMEOUT=50, PC stuck at 12 → `timed_out`=1 after 50 RUN cycles, `dump` still issued, `pass`=0.
- **Boundaries:**
  - Stop and timeout in the same cycle → `timed_out`=0.
  - DRAIN=0 → `dump` the cycle after stop.
  - A surplus writeback to x5 after the table is exhausted → `err_cnt`=1.
  - Writebacks to x0 are ignored.
- **Reset mid-run:** `reset`=0 during RUN → next cycle IDLE, `core_reset`=1, status cleared. A new `start` replays the basic run identically.
- **Start handling:** `start` pulses during HOLD/RUN are ignored, with no counter restart. A table write during RUN is dropped: readback via the mismatch path shows the old entry.
